// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the MEM pipeline stage: access-size
//               encodings, FSM state type, lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // Access-size encodings carried on size_i (2'b11 behaves as a word)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  // Byte enables for an access; half at offset 3 is truncated to the top lane
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes so the enabled lanes carry the value
  function automatic logic [31:0] wdata_fmt(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Half needs addr[0] = 0, word needs addr[1:0] = 00
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load-data extraction: shift the addressed
//               lane down, then sign- or zero-extend to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata_i >> {offset_i, 3'b000};

  // Select the access width and apply the requested extension
  always_comb begin
    data_o = w_shifted;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'd0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: data_o = unsigned_i ? {16'd0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: data_o = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline MEM stage. Performs data-memory loads/stores over a
//               req/ack handshake, stalls upstream while an access is in
//               flight and presents write-back fields to MEM/WB.
//               Optional macro MEM_ALIGN_CHECK_EN: misaligned half/word
//               accesses are suppressed and flagged on misalign_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              Mem2Reg_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       ALU_data_i,
  input  logic [31:0]       WriteData_i,
  input  logic [4:0]        RDaddr_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic              Mem2Reg_o,
  output logic [31:0]       ReadData_o,
  output logic [31:0]       ALU_data_o,
  output logic [4:0]        RDaddr_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [31:0]       dmem_rdata_i
);

  mem_state_t  r_state, w_state_nxt;

  logic        r_is_load, r_is_store, r_regwrite, r_mem2reg, r_unsigned, r_misalign;
  logic [1:0]  r_size;
  logic [31:0] r_alu, r_wdata, r_rdata;
  logic [4:0]  r_rd;

  logic        w_memop, w_misalign;
  logic [31:0] w_load_val;

  assign w_memop = valid_i & (MemRead_i | MemWrite_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = is_misaligned(size_i, ALU_data_i[1:0]);
  assign misalign_o = r_misalign;
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  mem_load_align u_load_align (
    .rdata_i    (dmem_rdata_i),
    .offset_i   (r_alu[1:0]),
    .size_i     (r_size),
    .unsigned_i (r_unsigned),
    .data_o     (w_load_val)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state: misaligned accesses skip the request phase entirely
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_memop) w_state_nxt = w_misalign ? ST_RESP : ST_REQ;
      ST_REQ:  if (dmem_ack_i) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the access in IDLE and the load result on ack
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_regwrite <= 1'b0;
      r_mem2reg  <= 1'b0;
      r_unsigned <= 1'b0;
      r_misalign <= 1'b0;
      r_size     <= 2'b00;
      r_alu      <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_rd       <= 5'd0;
    end else begin
      r_misalign <= (r_state == ST_IDLE) & w_memop & w_misalign;
      if ((r_state == ST_IDLE) && w_memop) begin
        r_is_load  <= MemRead_i;
        r_is_store <= MemWrite_i;
        r_regwrite <= RegWrite_i;
        r_mem2reg  <= Mem2Reg_i;
        r_unsigned <= unsigned_i;
        r_size     <= size_i;
        r_alu      <= ALU_data_i;
        r_wdata    <= wdata_fmt(size_i, WriteData_i);
        r_rd       <= RDaddr_i;
      end
      if ((r_state == ST_REQ) && dmem_ack_i) r_rdata <= w_load_val;
    end
  end

  // Memory port is driven only from latched state
  assign dmem_req_o   = (r_state == ST_REQ);
  assign dmem_we_o    = (r_state == ST_REQ) & r_is_store;
  assign dmem_addr_o  = {r_alu[ADDR_W-1:2], 2'b00};
  assign dmem_be_o    = be_gen(r_size, r_alu[1:0]);
  assign dmem_wdata_o = r_wdata;

  // Write-back outputs: pass-through, bubble while stalled, latched in RESP
  always_comb begin
    stall_o    = 1'b0;
    RegWrite_o = RegWrite_i;
    Mem2Reg_o  = Mem2Reg_i;
    ReadData_o = 32'd0;
    ALU_data_o = ALU_data_i;
    RDaddr_o   = RDaddr_i;
    case (r_state)
      ST_IDLE: begin
        if (w_memop) begin
          stall_o    = 1'b1;
          RegWrite_o = 1'b0;
          Mem2Reg_o  = 1'b0;
        end
      end
      ST_REQ: begin
        stall_o    = 1'b1;
        RegWrite_o = 1'b0;
        Mem2Reg_o  = 1'b0;
        ALU_data_o = r_alu;
        RDaddr_o   = r_rd;
      end
      ST_RESP: begin
        RegWrite_o = r_regwrite & ~r_misalign;
        Mem2Reg_o  = r_mem2reg & ~r_misalign;
        ReadData_o = (r_is_load & ~r_misalign) ? r_rdata : 32'd0;
        ALU_data_o = r_alu;
        RDaddr_o   = r_rd;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
//               Honours MEM_ALIGN_CHECK_EN for the alignment scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i, MemRead_i, MemWrite_i, RegWrite_i, Mem2Reg_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] ALU_data_i, WriteData_i;
  logic [4:0]  RDaddr_i;
  logic        stall_o, RegWrite_o, Mem2Reg_o, misalign_o;
  logic [31:0] ReadData_o, ALU_data_o;
  logic [4:0]  RDaddr_o;
  logic        dmem_req_o, dmem_we_o, dmem_ack_i;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o, dmem_rdata_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RegWrite_i(RegWrite_i), .Mem2Reg_i(Mem2Reg_i),
    .size_i(size_i), .unsigned_i(unsigned_i),
    .ALU_data_i(ALU_data_i), .WriteData_i(WriteData_i), .RDaddr_i(RDaddr_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .Mem2Reg_o(Mem2Reg_o),
    .ReadData_o(ReadData_o), .ALU_data_o(ALU_data_o), .RDaddr_o(RDaddr_o),
    .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [1:0] sz, input logic uns, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rdst);
    valid_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw; Mem2Reg_i = m2r;
    size_i = sz; unsigned_i = uns; ALU_data_i = alu; WriteData_i = wd; RDaddr_i = rdst;
  endtask

  task automatic clr_op();
    valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b0; Mem2Reg_i = 1'b0;
    size_i = 2'b00; unsigned_i = 1'b0; ALU_data_i = 32'd0; WriteData_i = 32'd0; RDaddr_i = 5'd0;
  endtask

  // Runs from the IDLE cycle of an access through to RESP; ack after `waits` REQ cycles
  task automatic access(input string tag, input int waits, input logic [3:0] be,
                        input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    #1;
    check({tag, " idle stall"}, 32'(stall_o), 32'd1);
    check({tag, " idle rw bubble"}, 32'(RegWrite_o), 32'd0);
    for (int i = 0; i <= waits; i++) begin
      tick();
      check({tag, " req"}, 32'(dmem_req_o), 32'd1);
      check({tag, " req stall"}, 32'(stall_o), 32'd1);
      check({tag, " req rw bubble"}, 32'(RegWrite_o), 32'd0);
      if (i == 0) begin
        check({tag, " be"}, 32'(dmem_be_o), 32'(be));
        check({tag, " we"}, 32'(dmem_we_o), 32'(we));
        check({tag, " addr"}, dmem_addr_o, addr);
        if (we) check({tag, " wdata"}, dmem_wdata_o, wdata);
      end
      if (i == waits) dmem_ack_i = 1'b1;
    end
    tick();
    dmem_ack_i = 1'b0;
    #1;
    check({tag, " resp stall"}, 32'(stall_o), 32'd0);
    check({tag, " resp req"}, 32'(dmem_req_o), 32'd0);
  endtask

  initial begin
    clr_op();
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0; rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset req", 32'(dmem_req_o), 32'd0);
    check("reset we", 32'(dmem_we_o), 32'd0);
    check("reset misalign", 32'(misalign_o), 32'd0);
    check("reset stall", 32'(stall_o), 32'd0);
    check("reset readdata", ReadData_o, 32'd0);
    rst_n_i = 1'b1;

    // Word load, zero wait
    tick();
    set_op(1, 0, 1, 1, 2'b10, 0, 32'h100, 32'd0, 5'd5);
    dmem_rdata_i = 32'hDEADBEEF;
    access("ldw", 0, 4'b1111, 1'b0, 32'h100, 32'd0);
    check("ldw data", ReadData_o, 32'hDEADBEEF);
    check("ldw rw", 32'(RegWrite_o), 32'd1);
    check("ldw m2r", 32'(Mem2Reg_o), 32'd1);
    check("ldw rd", 32'(RDaddr_o), 32'd5);

    // Signed byte load at top lane
    tick();
    set_op(1, 0, 1, 1, 2'b00, 0, 32'h103, 32'd0, 5'd9);
    dmem_rdata_i = 32'h80123456;
    access("lb", 0, 4'b1000, 1'b0, 32'h100, 32'd0);
    check("lb data", ReadData_o, 32'hFFFFFF80);

    // Unsigned byte load at the same address
    tick();
    set_op(1, 0, 1, 1, 2'b00, 1, 32'h103, 32'd0, 5'd9);
    access("lbu", 0, 4'b1000, 1'b0, 32'h100, 32'd0);
    check("lbu data", ReadData_o, 32'h00000080);

    // Half store with 3 wait cycles
    tick();
    set_op(0, 1, 0, 0, 2'b01, 0, 32'h202, 32'h0000ABCD, 5'd0);
    access("sh", 3, 4'b1100, 1'b1, 32'h200, 32'hABCDABCD);
    check("sh rw", 32'(RegWrite_o), 32'd0);
    check("sh data", ReadData_o, 32'd0);

    // Byte store, lane 1
    tick();
    set_op(0, 1, 0, 0, 2'b00, 0, 32'h001, 32'h1234565A, 5'd0);
    access("sb", 0, 4'b0010, 1'b1, 32'h000, 32'h5A5A5A5A);

    // Non-memory instruction: pass-through, no stall
    tick();
    set_op(0, 0, 1, 0, 2'b10, 0, 32'h55, 32'd0, 5'd7);
    #1;
    check("alu stall", 32'(stall_o), 32'd0);
    check("alu data", ALU_data_o, 32'h55);
    check("alu rd", 32'(RDaddr_o), 32'd7);
    check("alu rw", 32'(RegWrite_o), 32'd1);
    check("alu readdata", ReadData_o, 32'd0);
    tick();
    check("alu no req", 32'(dmem_req_o), 32'd0);

    // Reset while in REQ, then a late ack
    set_op(1, 0, 1, 1, 2'b10, 0, 32'h300, 32'd0, 5'd3);
    tick();
    check("rst pre req", 32'(dmem_req_o), 32'd1);
    rst_n_i = 1'b0;
    clr_op();
    #1;
    check("rst req", 32'(dmem_req_o), 32'd0);
    check("rst stall", 32'(stall_o), 32'd0);
    tick();
    rst_n_i = 1'b1;
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hFFFFFFFF;
    tick();
    dmem_ack_i = 1'b0;
    #1;
    check("late ack req", 32'(dmem_req_o), 32'd0);
    check("late ack rw", 32'(RegWrite_o), 32'd0);
    check("late ack data", ReadData_o, 32'd0);
    check("late ack stall", 32'(stall_o), 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word load: no request, one-cycle flag
    tick();
    set_op(1, 0, 1, 1, 2'b10, 0, 32'h101, 32'd0, 5'd4);
    #1;
    check("mis idle stall", 32'(stall_o), 32'd1);
    check("mis idle req", 32'(dmem_req_o), 32'd0);
    tick();
    check("mis resp req", 32'(dmem_req_o), 32'd0);
    check("mis flag", 32'(misalign_o), 32'd1);
    check("mis rw", 32'(RegWrite_o), 32'd0);
    check("mis data", ReadData_o, 32'd0);
    check("mis stall", 32'(stall_o), 32'd0);
    tick();
    clr_op();
    #1;
    check("mis flag clear", 32'(misalign_o), 32'd0);
`else
    // No alignment check: half at offset 3 issues with truncated enables
    tick();
    set_op(1, 0, 1, 1, 2'b01, 0, 32'h103, 32'd0, 5'd4);
    dmem_rdata_i = 32'hAB000000;
    access("lh3", 0, 4'b1000, 1'b0, 32'h100, 32'd0);
    check("lh3 data", ReadData_o, 32'h000000AB);
    check("lh3 misalign", 32'(misalign_o), 32'd0);
`endif

    tick();
    clr_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
